// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU execute-stage sequencer: opsel codes, flag bit
// positions, FSM state encoding and the EXEC watchdog limit.
package alu_exec_ctrl_pkg;

  localparam int unsigned OPSEL_W     = 5;
  localparam int unsigned TIMEOUT_CYC = 15;

  localparam logic [OPSEL_W-1:0] OP_NOP = 5'd0;
  localparam logic [OPSEL_W-1:0] OP_ADD = 5'd1;
  localparam logic [OPSEL_W-1:0] OP_SUB = 5'd2;
  localparam logic [OPSEL_W-1:0] OP_AND = 5'd3;
  localparam logic [OPSEL_W-1:0] OP_OR  = 5'd4;
  localparam logic [OPSEL_W-1:0] OP_XOR = 5'd5;

  localparam int unsigned FLAG_ZF = 3;
  localparam int unsigned FLAG_NF = 2;
  localparam int unsigned FLAG_CF = 1;
  localparam int unsigned FLAG_OF = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: fetch A/B, drive the ALU, write back and commit flags.
// Optional EXEC watchdog enabled by defining ALU_EXEC_TIMEOUT_EN.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rd,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  input  logic              no_wb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_srcA,
  output logic [DATA_W-1:0] alu_srcB,
  output logic [4:0]        alu_opsel,
  input  logic              alu_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [FLAG_W-1:0] alu_flag_next,
  output logic [FLAG_W-1:0] flags
);

  state_e              state_q, state_d;
  logic [4:0]          opsel_q, opsel_d;
  logic [REG_AW-1:0]   ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic                use_imm_q, use_imm_d, no_wb_q, no_wb_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   src_a_q, src_a_d, src_b_q, src_b_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [FLAG_W-1:0]   pend_q, pend_d, flags_q, flags_d;
  logic                timeout_c;

`ifdef ALU_EXEC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  // Counts EXEC cycles; fires on the last allowed cycle if the ALU is still not ready.
  assign wd_cnt_d  = (state_q == ST_EXEC) ? wd_cnt_q + CNT_W'(1) : '0;
  assign timeout_c = (state_q == ST_EXEC) && !alu_ready &&
                     (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    opsel_d   = opsel_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rd_d      = rd_q;
    use_imm_d = use_imm_q;
    no_wb_d   = no_wb_q;
    imm_d     = imm_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    wdata_d   = wdata_q;
    pend_d    = pend_q;
    flags_d   = flags_q;
    rf_raddr  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          opsel_d   = op;
          ra_d      = ra;
          rb_d      = rb;
          rd_d      = rd;
          use_imm_d = use_imm;
          no_wb_d   = no_wb;
          imm_d     = imm;
          state_d   = ST_RD_A;
        end
      end
      ST_RD_A: begin
        rf_raddr = ra_q;
        src_a_d  = rf_rdata;
        state_d  = ST_RD_B;
      end
      // Visited even for immediates so the issue-to-done latency never varies.
      ST_RD_B: begin
        rf_raddr = rb_q;
        src_b_d  = use_imm_q ? imm_q : rf_rdata;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (alu_ready) begin
          wdata_d = alu_res;
          pend_d  = alu_flag_next;
          state_d = ST_WB;
        end else if (timeout_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        flags_d = pend_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      opsel_q   <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      no_wb_q   <= 1'b0;
      imm_q     <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      wdata_q   <= '0;
      pend_q    <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      opsel_q   <= opsel_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rd_q      <= rd_d;
      use_imm_q <= use_imm_d;
      no_wb_q   <= no_wb_d;
      imm_q     <= imm_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      wdata_q   <= wdata_d;
      pend_q    <= pend_d;
      flags_q   <= flags_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_WB);
  assign rf_we     = (state_q == ST_WB) && !no_wb_q;
  assign err       = timeout_c;
  assign rf_waddr  = rd_q;
  assign rf_wdata  = wdata_q;
  assign alu_srcA  = src_a_q;
  assign alu_srcB  = src_b_q;
  assign alu_opsel = opsel_q;
  assign flags     = flags_q;

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage sequencer wrapped around the combinational ALU.
- Fetches two operands from the register file through its single read port, or takes an immediate for B, then drives the ALU.
- Waits for ALU ready, writes the result back and commits the flags register that feeds the ALU flags input.
- One instruction in flight; no overlap.

Parameters:
- DATA_W, 16, operand/result width.
- REG_AW, 3, register-file address width.
- FLAG_W, 4, flags width; bit order ZF=3, NF=2, CF=1, OF=0.
- TIMEOUT_CYC, 15, EXEC watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  issue request; sampled only in IDLE.
- op  in  5  ALU opsel code (shared opsel constants).
- ra  in  REG_AW  operand-A register.
- rb  in  REG_AW  operand-B register.
- rd  in  REG_AW  destination register.
- use_imm  in  1  B taken from imm, not rb.
- imm  in  DATA_W  immediate operand.
- no_wb  in  1  compare/test: update flags only, no register write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse (optional feature only; tied 0 otherwise).
- rf_raddr  out  REG_AW  register-file read address; rf_rdata is combinational.
- rf_rdata  in  DATA_W  register-file read data.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- alu_srcA  out  DATA_W  registered operand A.
- alu_srcB  out  DATA_W  registered operand B.
- alu_opsel  out  5  registered opcode.
- alu_ready  in  1  ALU result valid.
- alu_res  in  DATA_W  ALU result.
- alu_flag_next  in  FLAG_W  ALU next flags.
- flags  out  FLAG_W  architectural flags register; drives ALU flags input.

Behaviour:
- Reset: state=IDLE. busy, done, err, rf_we = 0. flags, alu_srcA, alu_srcB, alu_opsel, rf_waddr, rf_wdata = 0.
- FSM states: IDLE, RD_A, RD_B, EXEC, WB.
- IDLE: if start=1 at the edge, latch op, ra, rb, rd, use_imm, imm, no_wb; go to RD_A.
- RD_A: rf_raddr=ra; alu_srcA <= rf_rdata; go to RD_B.
- RD_B: rf_raddr=rb. alu_srcB <= use_imm ? imm : rf_rdata. The state is always visited, so latency is fixed. Go to EXEC.
- EXEC: alu_opsel is held stable for the whole state. At the edge where alu_ready=1, latch alu_res into rf_wdata and alu_flag_next into a pending register; go to WB. Otherwise remain in EXEC.
- WB: rf_we = ~no_wb; rf_waddr=rd; done=1. At the next edge, flags <= pending; go to IDLE.
- Latency with alu_ready constant 1: start edge E0; done and rf_we high in the cycle after E3; new flags visible after E4.
- Each extra alu_ready=0 cycle in EXEC adds exactly one cycle.
- Throughput: start is accepted again in the IDLE cycle after WB, so one instruction per 5 cycles.
- start while busy is ignored, with no queuing.
- ra==rb, and rd equal to ra or rb, are legal. The next instruction reads the written value.
- rf_raddr is don't-care outside RD_A/RD_B; drive 0.
- flags changes only on WB exit and on reset.
- Reset asserted in any state aborts immediately: no write, no done, flags cleared.

Optional Feature:
- Macro: ALU_EXEC_TIMEOUT_EN.
- With the macro defined: a cycle counter runs in EXEC. If alu_ready stays 0 for TIMEOUT_CYC consecutive EXEC cycles, err pulses for one cycle and the FSM returns to IDLE. In that case there is no rf_we, no done, and flags are unchanged.
- Without the macro: no counter; err is tied to 0; EXEC waits indefinitely.

Decomposition:
- Shared package (existing opsel include) holds:
  - ALU opsel code constants.
  - Flag bit indices ZF/NF/CF/OF.
  - The FSM state encoding.
- No sub-module. The watchdog counter is inline, under the macro.

Test Plan:
- ADD: r1=0x7FFF, r2=0x0001, rd=3, alu_ready=1 → r3=0x8000 written once; done at start+4; flags=4'b0101.
- SUB: r4=0x1234, r4 (ra=rb=4), rd=5 → r5=0x0000; flags=4'b1000.
- SUB with use_imm=1, imm=0x0001, r1=0x0000, no_wb=1 → no rf_we; flags=4'b0110 (NF and CF set).
- alu_ready held 0 for 3 EXEC cycles → done at start+7; opsel and operands stable throughout; start pulsed during busy is ignored.
- rst=1 in the EXEC cycle with rf_we pending → no write, no done; flags=0; next start behaves normally.
- With ALU_EXEC_TIMEOUT_EN and alu_ready tied 0 → err pulses on EXEC cycle 15; flags unchanged; FSM returns to IDLE.
